// File: rtl/rbz_spi_pkg.sv
// Shared SPI definitions for the raybox-zero peripheral transmitter and its responder model.
package rbz_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_HIGH,
    ST_LOW,
    ST_GAP
  } spi_state_e;

  // Mode 0: sclk idles low, data sampled on the rising edge
  localparam logic CPOL = 1'b0;
  localparam logic CPHA = 1'b0;

  localparam int unsigned DIV_W = 8;

  function automatic int unsigned len_w(input int unsigned max_bits);
    return $clog2(max_bits + 1);
  endfunction

endpackage

// File: rtl/rbz_spi_tx_tick.sv
// Phase timer: strobes phase_end_c on the last of CLK_DIV cycles; restarts on every state change.
module rbz_spi_tx_tick
  import rbz_spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic en,
  output logic phase_end_c
);

  logic [DIV_W-1:0] cnt_q;

  assign phase_end_c = en && (cnt_q == DIV_W'(CLK_DIV - 1));

  // Transitions only happen on phase_end_c, so clearing there doubles as clear-on-entry
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt_q <= '0;
    end else if (!en || phase_end_c) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + DIV_W'(1);
    end
  end

endmodule

// File: rtl/rbz_spi_tx.sv
// Mode-0 write-only SPI transmitter for raybox-zero vector/register ports.
// Define RBZ_SPI_TX_VBLANK_SYNC_EN to only start frames while i_vblank is high.
module rbz_spi_tx
  import rbz_spi_pkg::*;
#(
  parameter  int unsigned CLK_DIV  = 2,
  parameter  int unsigned MAX_BITS = 80,
  localparam int unsigned LEN_W    = len_w(MAX_BITS)
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [MAX_BITS-1:0] i_data,
  input  logic [LEN_W-1:0]    i_len,
  output logic                o_csb,
  output logic                o_sclk,
  output logic                o_mosi,
  output logic                o_busy,
  output logic                o_done,
  input  logic                i_vblank
);

  spi_state_e          state_q, state_d;
  logic [MAX_BITS-1:0] shreg_q, shreg_d;
  logic [LEN_W-1:0]    bits_q, bits_d;
  logic [LEN_W-1:0]    len_cl_c;
  logic                csb_q, csb_d;
  logic                sclk_q, sclk_d;
  logic                mosi_q, mosi_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                gate_c;
  logic                accept_c;
  logic                phase_end_c;

`ifdef RBZ_SPI_TX_VBLANK_SYNC_EN
  assign gate_c = i_vblank;
`else
  logic unused_vblank;
  assign unused_vblank = i_vblank;
  assign gate_c        = 1'b1;
`endif

  assign o_ready  = ready_q & gate_c;
  assign accept_c = i_valid & o_ready;
  assign len_cl_c = (i_len > LEN_W'(MAX_BITS)) ? LEN_W'(MAX_BITS) : i_len;

  assign o_csb  = csb_q;
  assign o_sclk = sclk_q;
  assign o_mosi = mosi_q;
  assign o_busy = busy_q;
  assign o_done = done_q;

  rbz_spi_tx_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .en          (state_q != ST_IDLE),
    .phase_end_c (phase_end_c)
  );

  // Next-state and next-output logic; outputs are registered alongside the state
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bits_d  = bits_q;
    csb_d   = csb_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          // Left-justify so the first bit always sits at the MSB
          shreg_d = i_data << (LEN_W'(MAX_BITS) - len_cl_c);
          bits_d  = len_cl_c;
          if (len_cl_c == '0) begin
            state_d = ST_GAP;
            done_d  = 1'b1;
          end else begin
            state_d = ST_SETUP;
            csb_d   = 1'b0;
            mosi_d  = shreg_d[MAX_BITS-1];
          end
        end
      end
      ST_SETUP: begin
        if (phase_end_c) begin
          state_d = ST_HIGH;
          sclk_d  = ~CPOL;
        end
      end
      ST_HIGH: begin
        if (phase_end_c) begin
          state_d = ST_LOW;
          sclk_d  = CPOL;
          bits_d  = bits_q - LEN_W'(1);
          if (bits_q != LEN_W'(1)) begin
            shreg_d = shreg_q << 1;
            mosi_d  = shreg_d[MAX_BITS-1];
          end
        end
      end
      ST_LOW: begin
        if (phase_end_c) begin
          if (bits_q != '0) begin
            state_d = ST_HIGH;
            sclk_d  = ~CPOL;
          end else begin
            state_d = ST_GAP;
            csb_d   = 1'b1;
            mosi_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (phase_end_c) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        csb_d   = 1'b1;
        sclk_d  = CPOL;
        mosi_d  = 1'b0;
      end
    endcase

    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      bits_q  <= '0;
      csb_q   <= 1'b1;
      sclk_q  <= CPOL;
      mosi_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bits_q  <= bits_d;
      csb_q   <= csb_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_rbz_spi_tx.sv
// Directed bench for rbz_spi_tx: CLK_DIV=2 (u_dut0) and CLK_DIV=1 (u_dut1) instances, MAX_BITS=80.
module tb_rbz_spi_tx;

  logic        clk;
  logic        rst_n;
  logic [1:0]  valid;
  logic [79:0] data;
  logic [6:0]  len;
  logic        vblank;
  logic [1:0]  ready, csb, sclk, mosi, busy, done;

  int n_checks;
  int n_err;

  // Per-frame observations filled by measure()
  int          rises, csb_low, done_cnt, done_k, busy_k, idle_k, stab_err, first_rise_k, last_rise_k;
  logic        ready_at_idle;
  logic [79:0] bits;

  // Back-to-back bookkeeping
  logic [3:0] bits_a, bits_b;
  int         hi_run, g;
  logic       ps, seen_low, in_second;

  rbz_spi_tx #(.CLK_DIV(2), .MAX_BITS(80)) u_dut0 (
    .i_clk(clk), .i_reset_n(rst_n), .i_valid(valid[0]), .o_ready(ready[0]),
    .i_data(data), .i_len(len), .o_csb(csb[0]), .o_sclk(sclk[0]), .o_mosi(mosi[0]),
    .o_busy(busy[0]), .o_done(done[0]), .i_vblank(vblank)
  );

  rbz_spi_tx #(.CLK_DIV(1), .MAX_BITS(80)) u_dut1 (
    .i_clk(clk), .i_reset_n(rst_n), .i_valid(valid[1]), .o_ready(ready[1]),
    .i_data(data), .i_len(len), .o_csb(csb[1]), .o_sclk(sclk[1]), .o_mosi(mosi[1]),
    .o_busy(busy[1]), .o_done(done[1]), .i_vblank(vblank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (observed timeout, required completion)");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_v(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request and return one cycle after the accepting edge (k=1)
  task automatic send(input int w, input logic [79:0] d, input logic [6:0] l);
    int gw;
    gw = 0;
    data = d;
    len  = l;
    valid[w] = 1'b1;
    while (ready[w] !== 1'b1 && gw < 100) begin
      tick();
      gw++;
    end
    chk_i("accept_wait", int'(gw < 100), 1);
    tick();
    valid[w] = 1'b0;
  endtask

  // Observe from k=1 until busy drops
  task automatic measure(input int w);
    logic sp, mp;
    sp = 1'b0; mp = 1'b0;
    rises = 0; csb_low = 0; done_cnt = 0; done_k = 0; busy_k = 0; idle_k = 0;
    stab_err = 0; first_rise_k = 0; last_rise_k = 0; bits = '0; ready_at_idle = 1'b0;
    for (int k = 1; k <= 400; k++) begin
      if (csb[w] === 1'b0) csb_low++;
      if (done[w] === 1'b1) begin done_cnt++; done_k = k; end
      if (busy[w] === 1'b1 && busy_k == 0) busy_k = k;
      if (sclk[w] === 1'b1 && sp === 1'b0) begin
        rises++;
        bits = {bits[78:0], mosi[w]};
        if (first_rise_k == 0) first_rise_k = k;
        last_rise_k = k;
      end
      if (sclk[w] === 1'b1 && sp === 1'b1 && mosi[w] !== mp) stab_err++;
      sp = sclk[w];
      mp = mosi[w];
      if (busy[w] !== 1'b1) begin
        idle_k = k;
        ready_at_idle = ready[w];
        break;
      end
      tick();
    end
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    valid    = 2'b00;
    data     = '0;
    len      = '0;
    vblank   = 1'b1;

    // Reset state
    tick(); tick();
    chk_b("rst_csb",   csb[0],   1'b1);
    chk_b("rst_sclk",  sclk[0],  1'b0);
    chk_b("rst_mosi",  mosi[0],  1'b0);
    chk_b("rst_ready", ready[0], 1'b1);
    chk_b("rst_busy",  busy[0],  1'b0);
    chk_b("rst_done",  done[0],  1'b0);
    rst_n = 1'b1;
    tick(); tick();

    // CLK_DIV=2, 8'hA5: csb low (1+16)*2=34, done at k=35, idle/ready at k=37
    send(0, 80'hA5, 7'd8);
    measure(0);
    chk_i("a5_rises",     rises,    8);
    chk_v("a5_bits",      bits,     80'hA5);
    chk_i("a5_csb_low",   csb_low,  34);
    chk_i("a5_done_cnt",  done_cnt, 1);
    chk_i("a5_done_k",    done_k,   35);
    chk_i("a5_busy_k",    busy_k,   1);
    chk_i("a5_idle_k",    idle_k,   37);
    chk_b("a5_ready",     ready_at_idle, 1'b1);
    chk_i("a5_stable",    stab_err, 0);

    // Zero-length frame: done at k=1, ready after 1+CLK_DIV = k=3
    send(0, 80'hFF, 7'd0);
    measure(0);
    chk_i("len0_rises",   rises,    0);
    chk_i("len0_csb_low", csb_low,  0);
    chk_i("len0_done_k",  done_k,   1);
    chk_i("len0_done_n",  done_cnt, 1);
    chk_i("len0_idle_k",  idle_k,   3);
    chk_b("len0_ready",   ready_at_idle, 1'b1);

    // CLK_DIV=1, 80 alternating bits: rises every 2 cycles at k=2..160
    send(1, {40{2'b01}}, 7'd80);
    measure(1);
    chk_i("alt_rises",    rises,    80);
    chk_v("alt_bits",     bits,     {40{2'b01}});
    chk_i("alt_csb_low",  csb_low,  161);
    chk_i("alt_idle_k",   idle_k,   163);
    chk_i("alt_period",   last_rise_k - first_rise_k, 158);
    chk_i("alt_stable",   stab_err, 0);
    chk_i("alt_done_cnt", done_cnt, 1);

    // Oversized length clamps to 80
    send(1, 80'h1234_5678_9ABC_DEF0_1357, 7'd127);
    measure(1);
    chk_i("clamp_rises",  rises,    80);
    chk_v("clamp_bits",   bits,     80'h1234_5678_9ABC_DEF0_1357);
    chk_i("clamp_idle_k", idle_k,   163);

    // Back-to-back with valid held: csb high run is GAP (2) plus the IDLE accept cycle
    data = 80'hC; len = 7'd4; valid[0] = 1'b1;
    g = 0;
    while (ready[0] !== 1'b1 && g < 100) begin tick(); g++; end
    tick();
    data = 80'h3;
    rises = 0; done_cnt = 0; hi_run = 0; bits_a = '0; bits_b = '0;
    ps = 1'b0; seen_low = 1'b0; in_second = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (sclk[0] === 1'b1 && ps === 1'b0) begin
        rises++;
        if (rises <= 4) bits_a = {bits_a[2:0], mosi[0]};
        else            bits_b = {bits_b[2:0], mosi[0]};
      end
      ps = sclk[0];
      if (csb[0] === 1'b0) begin
        if (hi_run > 0) in_second = 1'b1;
        seen_low = 1'b1;
      end else if (seen_low && !in_second) begin
        hi_run++;
      end
      if (done[0] === 1'b1) done_cnt++;
      if (done_cnt == 2) break;
      tick();
    end
    valid[0] = 1'b0;
    chk_v("b2b_first",   80'(bits_a), 80'hC);
    chk_v("b2b_second",  80'(bits_b), 80'h3);
    chk_i("b2b_gap",     hi_run,   3);
    chk_i("b2b_done",    done_cnt, 2);
    chk_i("b2b_rises",   rises,    8);
    g = 0;
    while (ready[0] !== 1'b1 && g < 100) begin tick(); g++; end

`ifdef RBZ_SPI_TX_VBLANK_SYNC_EN
    // Gate closed: no accept; open: accept next edge; close mid-frame: frame completes
    vblank = 1'b0; data = 80'hA5; len = 7'd8; valid[0] = 1'b1;
    tick(); tick(); tick();
    chk_b("vb_ready_low", ready[0], 1'b0);
    chk_b("vb_no_accept", busy[0],  1'b0);
    vblank = 1'b1;
    #1;
    chk_b("vb_ready_high", ready[0], 1'b1);
    tick();
    valid[0] = 1'b0;
    vblank   = 1'b0;
    measure(0);
    chk_i("vb_busy_k", busy_k, 1);
    chk_i("vb_rises",  rises,  8);
    chk_v("vb_bits",   bits,   80'hA5);
    chk_i("vb_idle_k", idle_k, 37);
    chk_b("vb_ready_gated", ready_at_idle, 1'b0);
    vblank = 1'b1;
    tick();
`endif

    // Asynchronous reset mid-frame, during HIGH
    send(0, 80'hA5, 7'd8);
    g = 0;
    while (sclk[0] !== 1'b1 && g < 50) begin tick(); g++; end
    chk_b("mid_in_high", sclk[0], 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_b("mid_rst_csb",  csb[0],  1'b1);
    chk_b("mid_rst_sclk", sclk[0], 1'b0);
    chk_b("mid_rst_busy", busy[0], 1'b0);
    chk_b("mid_rst_done", done[0], 1'b0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk_b("post_rst_ready", ready[0], 1'b1);
    chk_b("post_rst_done",  done[0],  1'b0);
    chk_b("post_rst_csb",   csb[0],   1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
